// File: rtl/tap_cmds_mc_pkg.sv
// Shared definitions for the multi-channel TAP command decoder.
// Optional macro TAP_CMD_STATS_EN enables the GET_STATS instruction.
package tap_cmds_mc_pkg;

    // Command word layout: [31:28] target, [27:24] instr, [23:20] ch, [19:0] payload
    localparam int TGT_LO = 28;
    localparam int INS_LO = 24;
    localparam int CH_LO  = 20;
    localparam int PAY_W  = 20;

    localparam logic [3:0] TAP_TARGET    = 4'h3;
    localparam logic [3:0] INS_SET_GT    = 4'd0;
    localparam logic [3:0] INS_SET_ET    = 4'd1;
    localparam logic [3:0] INS_SET_LT    = 4'd2;
    localparam logic [3:0] INS_SET_THR   = 4'd3;
    localparam logic [3:0] INS_SET_TRIG  = 4'd4;
    localparam logic [3:0] INS_GET_CTL   = 4'd5;
    localparam logic [3:0] INS_APPLY     = 4'd6;
    localparam logic [3:0] INS_GET_STATS = 4'd7;
    localparam logic [3:0] ERR_CODE      = 4'hF;
    localparam logic [3:0] BCAST_CH      = 4'hF;

    // Per-channel ctl layout: {thr, trig_en, lt, et, gt}
    localparam int CTL_GT    = 0;
    localparam int CTL_ET    = 1;
    localparam int CTL_LT    = 2;
    localparam int CTL_TRIG  = 3;
    localparam int CTL_THR   = 4;
    localparam int CTL_FLAGS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic ins_legal(input logic [3:0] ins);
`ifdef TAP_CMD_STATS_EN
        return ins <= INS_GET_STATS;
`else
        return ins <= INS_APPLY;
`endif
    endfunction

    function automatic logic ins_is_set(input logic [3:0] ins);
        return ins <= INS_SET_TRIG;
    endfunction

endpackage

// File: rtl/tap_cmds_mc_if.sv
// Command/response bus and live control outputs of the TAP command decoder.
// Handshake: a command is taken only when run=1 while the block is idle; done pulses once with rsp valid.
interface tap_cmds_if #(
    parameter int N_CH  = 4,
    parameter int THR_W = 14
);
    logic                          run;
    logic [31:0]                   cmd;
    logic                          busy;
    logic                          done;
    logic [31:0]                   rsp;
    logic [N_CH*(THR_W+4)-1:0]     ctl;
    logic                          apply_stb;

    modport master (output run, cmd, input busy, done, rsp, ctl, apply_stb);
    modport slave  (input run, cmd, output busy, done, rsp, ctl, apply_stb);
endinterface

// File: rtl/tap_cmds_mc_ch_regs.sv
// One channel's live mode bits, trigger enable, live threshold and shadow threshold.
module tap_ch_regs
    import tap_cmds_mc_pkg::*;
#(
    parameter int THR_W    = 14,
    parameter int THR_INIT = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we_i,
    input  logic [3:0]                sel_i,
    input  logic [THR_W-1:0]          wdata_i,
    input  logic                      apply_i,
    output logic [THR_W+CTL_FLAGS-1:0] ctl_o
);
    logic             gt_q, et_q, lt_q, trig_q;
    logic [THR_W-1:0] thr_q, shd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gt_q   <= 1'b0;
            et_q   <= 1'b0;
            lt_q   <= 1'b0;
            trig_q <= 1'b0;
            thr_q  <= THR_W'(THR_INIT);
            shd_q  <= THR_W'(THR_INIT);
        end else begin
            if (we_i) begin
                case (sel_i)
                    INS_SET_GT:   gt_q   <= wdata_i[0];
                    INS_SET_ET:   et_q   <= wdata_i[0];
                    INS_SET_LT:   lt_q   <= wdata_i[0];
                    INS_SET_THR:  shd_q  <= wdata_i;
                    INS_SET_TRIG: trig_q <= wdata_i[0];
                    default: ;
                endcase
            end
            // Live threshold only ever moves via apply, never via SET_THR.
            if (apply_i) thr_q <= shd_q;
        end
    end

    assign ctl_o = {thr_q, trig_q, lt_q, et_q, gt_q};
endmodule

// File: rtl/tap_cmds_mc.sv
// Multi-channel TAP command decoder: IDLE -> EXEC (1 or N_CH cycles) -> RESP.
// Optional macro TAP_CMD_STATS_EN adds saturating command/error counters and GET_STATS.
module tap_cmds_mc
    import tap_cmds_mc_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int THR_W    = 14,
    parameter int THR_INIT = 0
) (
    input  logic      clk,
    input  logic      rst,
    tap_cmds_if.slave bus,
    output state_e    state_o
);
    localparam int CW = THR_W + CTL_FLAGS;

    state_e      state_q, state_d;
    logic [31:0] cmd_q, cmd_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] rsp_q, rsp_d;

    logic [3:0]  ins, ch;
    logic        is_set, bcast, err, exec, apply, capture;
    logic [CW-1:0] ctl_arr [N_CH];
    logic [CW-1:0] sel_ctl;
    logic [N_CH-1:0] ch_we;

    assign ins     = cmd_q[INS_LO +: 4];
    assign ch      = cmd_q[CH_LO +: 4];
    assign is_set  = ins_is_set(ins);
    assign bcast   = is_set && (ch == BCAST_CH);
    assign err     = !ins_legal(ins)
                   || ((is_set || ins == INS_GET_CTL) && (int'(ch) >= N_CH) && (ch != BCAST_CH))
                   || ((ins == INS_GET_CTL) && (ch == BCAST_CH));
    assign exec    = (state_q == ST_EXEC);
    assign apply   = exec && !err && (ins == INS_APPLY);
    assign capture = (state_q == ST_IDLE) && bus.run && (bus.cmd[TGT_LO +: 4] == TAP_TARGET);

    genvar gc;
    generate
        for (gc = 0; gc < N_CH; gc++) begin : g_ch
            // Broadcast walks channels by idx_q; unicast targets ch directly.
            assign ch_we[gc] = exec && !err && is_set
                             && (bcast ? (idx_q == 4'(gc)) : (ch == 4'(gc)));
            tap_ch_regs #(.THR_W(THR_W), .THR_INIT(THR_INIT)) u_regs (
                .clk     (clk),
                .rst     (rst),
                .we_i    (ch_we[gc]),
                .sel_i   (ins),
                .wdata_i (cmd_q[THR_W-1:0]),
                .apply_i (apply),
                .ctl_o   (ctl_arr[gc])
            );
            assign bus.ctl[gc*CW +: CW] = ctl_arr[gc];
        end
    endgenerate

    always_comb begin
        sel_ctl = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (ch == 4'(c)) sel_ctl = ctl_arr[c];
        end
    end

`ifdef TAP_CMD_STATS_EN
    logic [15:0] cmd_cnt_q, err_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            if (capture && (bus.cmd[INS_LO +: 4] != INS_GET_STATS) && (cmd_cnt_q != 16'hFFFF))
                cmd_cnt_q <= cmd_cnt_q + 16'd1;
            // cmd_q is still the finished command during RESP.
            if ((state_q == ST_RESP) && err && (err_cnt_q != 16'hFFFF))
                err_cnt_q <= err_cnt_q + 16'd1;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        idx_d   = idx_q;
        rsp_d   = rsp_q;
        case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    cmd_d   = bus.cmd;
                    idx_d   = '0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (err) begin
                    rsp_d   = {cmd_q[31:28], ERR_CODE, cmd_q[23:0]};
                    state_d = ST_RESP;
                end else if (bcast) begin
                    if (idx_q == 4'(N_CH - 1)) begin
                        rsp_d   = cmd_q;
                        state_d = ST_RESP;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    state_d = ST_RESP;
                    case (ins)
                        INS_GET_CTL:   rsp_d = {cmd_q[31:20], 20'(sel_ctl)};
`ifdef TAP_CMD_STATS_EN
                        INS_GET_STATS: rsp_d = {cmd_cnt_q, err_cnt_q};
`endif
                        default:       rsp_d = cmd_q;
                    endcase
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            idx_q   <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            idx_q   <= idx_d;
            rsp_q   <= rsp_d;
        end
    end

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_RESP);
    assign bus.rsp       = rsp_q;
    assign bus.apply_stb = apply;
    assign state_o       = state_q;
endmodule

// File: tb/tb_tap_cmds_mc.sv
// Directed and random checks of tap_cmds_mc against a channel-array reference model.
module tb_tap_cmds_mc;
    import tap_cmds_mc_pkg::*;

    localparam int N_CH     = 4;
    localparam int THR_W    = 14;
    localparam int THR_INIT = 5;
    localparam int CW       = THR_W + 4;
    localparam int CTLW     = N_CH * CW;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    state_e state_dbg;

    tap_cmds_if #(.N_CH(N_CH), .THR_W(THR_W)) bus ();

    tap_cmds_mc #(.N_CH(N_CH), .THR_W(THR_W), .THR_INIT(THR_INIT)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .state_o (state_dbg)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: plain per-channel arrays plus command counters.
    logic             m_gt [N_CH];
    logic             m_et [N_CH];
    logic             m_lt [N_CH];
    logic             m_trig [N_CH];
    logic [THR_W-1:0] m_thr [N_CH];
    logic [THR_W-1:0] m_shd [N_CH];
    int               m_cmd_cnt;
    int               m_err_cnt;
    logic [31:0]      exp_q[$];
    logic [31:0]      last_rsp;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CTLW-1:0] model_ctl();
        logic [CTLW-1:0] v;
        v = '0;
        for (int c = 0; c < N_CH; c++)
            v[c*CW +: CW] = {m_thr[c], m_trig[c], m_lt[c], m_et[c], m_gt[c]};
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_gt[c] = 0; m_et[c] = 0; m_lt[c] = 0; m_trig[c] = 0;
            m_thr[c] = THR_W'(THR_INIT);
            m_shd[c] = THR_W'(THR_INIT);
        end
        m_cmd_cnt = 0;
        m_err_cnt = 0;
        exp_q.delete();
    endtask

    task automatic model_cmd(input logic [31:0] cw, output int lat, output int stb);
        int ins, ch, max_ins;
        bit err, is_set, bc;
        logic [CTLW-1:0] v;
        ins = int'(cw[27:24]);
        ch  = int'(cw[23:20]);
`ifdef TAP_CMD_STATS_EN
        max_ins = 7;
`else
        max_ins = 6;
`endif
        is_set = (ins <= 4);
        bc     = (ch == 15);
        err = (ins > max_ins) || (is_set && !bc && ch >= N_CH) || (ins == 5 && (bc || ch >= N_CH));
        lat = 2;
        stb = 0;
        if (ins != 7 && m_cmd_cnt < 65535) m_cmd_cnt++;
        if (err) begin
            exp_q.push_back({cw[31:28], 4'hF, cw[23:0]});
            if (m_err_cnt < 65535) m_err_cnt++;
        end else if (is_set) begin
            for (int c = 0; c < N_CH; c++) begin
                if (bc || c == ch) begin
                    case (ins)
                        0: m_gt[c]   = cw[0];
                        1: m_et[c]   = cw[0];
                        2: m_lt[c]   = cw[0];
                        3: m_shd[c]  = cw[THR_W-1:0];
                        default: m_trig[c] = cw[0];
                    endcase
                end
            end
            if (bc) lat = 1 + N_CH;
            exp_q.push_back(cw);
        end else if (ins == 5) begin
            v = model_ctl();
            exp_q.push_back({cw[31:20], 20'(v[ch*CW +: CW])});
        end else if (ins == 6) begin
            for (int c = 0; c < N_CH; c++) m_thr[c] = m_shd[c];
            stb = 1;
            exp_q.push_back(cw);
        end else begin
            exp_q.push_back({16'(m_cmd_cnt), 16'(m_err_cnt)});
        end
    endtask

    // Drives one command; with junk set, run stays high with another command while busy.
    task automatic send(input logic [31:0] cw, input bit junk, output logic [31:0] r,
                        output int lat, output int bcyc, output int scnt);
        bus.cmd = cw;
        bus.run = 1'b1;
        @(posedge clk); #1;
        bus.run = junk;
        bus.cmd = {TAP_TARGET, INS_SET_GT, 4'h0, 20'h1};
        lat = 0; bcyc = 0; scnt = 0; r = '0;
        for (int k = 1; k <= 40; k++) begin
            if (bus.busy) bcyc++;
            if (bus.apply_stb) scnt++;
            if (bus.done) begin
                lat = k;
                r = bus.rsp;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.run = 1'b0;
    endtask

    task automatic run_checked(input string tag, input logic [31:0] cw, input bit junk);
        int elat, estb, lat, bcyc, scnt;
        logic [31:0] r, e;
        model_cmd(cw, elat, estb);
        send(cw, junk, r, lat, bcyc, scnt);
        e = exp_q.pop_front();
        chk({tag, "_lat"}, 128'(lat), 128'(elat));
        chk({tag, "_rsp"}, 128'(r), 128'(e));
        chk({tag, "_busy_cycles"}, 128'(bcyc), 128'(elat));
        chk({tag, "_apply_stb"}, 128'(scnt), 128'(estb));
        chk({tag, "_ctl"}, 128'(bus.ctl), 128'(model_ctl()));
        chk({tag, "_idle_after"}, 128'({bus.busy, bus.done}), 128'(0));
        last_rsp = r;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.run = 1'b0;
        bus.cmd = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    function automatic logic [31:0] mk(input logic [3:0] ins, input logic [3:0] ch, input logic [19:0] pay);
        return {TAP_TARGET, ins, ch, pay};
    endfunction

    initial begin
        logic [3:0] rch, rins;
        int sel;
        bus.run = 1'b0;
        bus.cmd = '0;
        do_reset();

        chk("reset_busy", 128'(bus.busy), 128'(0));
        chk("reset_done", 128'(bus.done), 128'(0));
        chk("reset_rsp", 128'(bus.rsp), 128'(0));
        chk("reset_apply_stb", 128'(bus.apply_stb), 128'(0));
        chk("reset_ctl", 128'(bus.ctl), 128'(model_ctl()));

        run_checked("set_gt_ch2", mk(INS_SET_GT, 4'd2, 20'h1), 1'b0);
        chk("set_gt_ch2_only", 128'(bus.ctl[2*CW +: 4]), 128'(1));

        run_checked("set_thr_ch1", mk(INS_SET_THR, 4'd1, 20'h1234), 1'b0);
        run_checked("get_ctl_pre_apply", mk(INS_GET_CTL, 4'd1, 20'h0), 1'b0);
        chk("thr_pre_apply", 128'(last_rsp[17:4]), 128'(THR_INIT));
        run_checked("apply", mk(INS_APPLY, 4'd9, 20'h0), 1'b0);
        chk("thr_post_apply", 128'(bus.ctl[CW + 4 +: THR_W]), 128'(14'h1234));
        run_checked("get_ctl_post_apply", mk(INS_GET_CTL, 4'd1, 20'h0), 1'b0);
        chk("get_thr_post_apply", 128'(last_rsp[17:4]), 128'(14'h1234));

        run_checked("bcast_trig", mk(INS_SET_TRIG, BCAST_CH, 20'h1), 1'b1);
        for (int c = 0; c < N_CH; c++)
            chk("bcast_trig_bit", 128'(bus.ctl[c*CW + 3]), 128'(1));

        run_checked("err_ch5", mk(INS_SET_GT, 4'd5, 20'h1), 1'b0);
        chk("err_ch5_code", 128'(last_rsp[27:24]), 128'(4'hF));
        run_checked("err_get_bcast", mk(INS_GET_CTL, BCAST_CH, 20'h0), 1'b0);
        chk("err_get_bcast_code", 128'(last_rsp[27:24]), 128'(4'hF));
        run_checked("err_ins9", mk(4'h9, 4'd0, 20'h1), 1'b0);
        chk("err_ins9_code", 128'(last_rsp[27:24]), 128'(4'hF));
`ifndef TAP_CMD_STATS_EN
        run_checked("err_ins7", mk(INS_GET_STATS, 4'd0, 20'h0), 1'b0);
        chk("err_ins7_code", 128'(last_rsp[27:24]), 128'(4'hF));
`endif

        // Foreign target: nothing may react.
        bus.cmd = {4'h9, INS_SET_GT, 4'd0, 20'h1};
        bus.run = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("foreign_busy_done", 128'({bus.busy, bus.done}), 128'(0));
        end
        bus.run = 1'b0;
        chk("foreign_ctl", 128'(bus.ctl), 128'(model_ctl()));

`ifdef TAP_CMD_STATS_EN
        do_reset();
        run_checked("st_good1", mk(INS_SET_GT, 4'd0, 20'h1), 1'b0);
        run_checked("st_good2", mk(INS_SET_ET, 4'd1, 20'h1), 1'b0);
        run_checked("st_good3", mk(INS_APPLY, 4'd0, 20'h0), 1'b0);
        run_checked("st_bad", mk(4'hA, 4'd0, 20'h0), 1'b0);
        run_checked("get_stats", mk(INS_GET_STATS, 4'd3, 20'h0), 1'b0);
        chk("get_stats_value", 128'(last_rsp), 128'(32'h0004_0001));
`endif

        for (int i = 0; i < 80; i++) begin
            rins = 4'($urandom_range(0, 9));
            sel = $urandom_range(0, 9);
            if (sel < 6)      rch = 4'($urandom_range(0, N_CH - 1));
            else if (sel < 8) rch = BCAST_CH;
            else              rch = 4'($urandom_range(N_CH, 14));
            run_checked("rand", mk(rins, rch, 20'($urandom)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a broadcast aborts it with no done.
        bus.cmd = mk(INS_SET_GT, BCAST_CH, 20'h1);
        bus.run = 1'b1;
        @(posedge clk); #1;
        bus.run = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        model_reset();
        chk("midrst_ctl", 128'(bus.ctl), 128'(model_ctl()));
        chk("midrst_busy", 128'(bus.busy), 128'(0));
        chk("midrst_rsp", 128'(bus.rsp), 128'(0));
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("midrst_no_done", 128'(bus.done), 128'(0));
        end
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("post_rst_idle", 128'({bus.busy, bus.done}), 128'(0));
        end
        chk("post_rst_ctl", 128'(bus.ctl), 128'(model_ctl()));
        run_checked("post_rst_cmd", mk(INS_SET_LT, 4'd3, 20'h1), 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/tap_cmds_mc.md
Name: tap_cmds_mc

Overview:
Multi-channel successor to the single-channel tap command decoder. Decodes 32-bit TAP-target commands from the shared command bus. Maintains per-channel comparator/trigger control: gt/et/lt mode bits, trigger enable, and a shadowed threshold. Adds broadcast writes, channel readback, a synchronous threshold-apply, and a run/busy/done handshake.

Parameters:
N_CH, 4, number of tap channels (1..15)
THR_W, 14, threshold width per channel (<=16)
THR_INIT, 0, reset value of live and shadow thresholds

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
run  in  1  command strobe; cmd valid this cycle
cmd  in  32  command word
busy  out  1  block is executing a command
done  out  1  one-cycle pulse; rsp valid
rsp  out  32  response word
ctl  out  N_CH*(THR_W+4)  per-channel live control; channel c at [c*(THR_W+4) +: THR_W+4] = {thr, trig_en, lt, et, gt}
apply_stb  out  1  one-cycle pulse when live thresholds change via APPLY

Behaviour:
- Clocking and reset: one clock (clk). Reset is asynchronous and active-high (rst).
- Command fields: [31:28] target, [27:24] instr, [23:20] ch, [19:0] payload.
  - ch=0xF means broadcast.
- Instr codes: 0 SET_GT, 1 SET_ET, 2 SET_LT, 3 SET_THR (payload[THR_W-1:0] -> shadow thr), 4 SET_TRIG_EN, 5 GET_CTL, 6 APPLY (ch ignored).
  - Codes 0,1,2,4 take payload[0] into the live bit.
  - 7 GET_STATS exists only with the optional feature.
  - All other codes are illegal.
- Reset values:
  - all mode bits and trig_en 0; live and shadow thr = THR_INIT
  - busy=0, done=0, rsp=0, apply_stb=0, FSM=IDLE.
  - Reset mid-command aborts the command with no done.
- FSM states:
  - IDLE: on run with target==TAP, latch cmd and go to EXEC. Run with any other target is ignored and the FSM stays in IDLE.
  - EXEC, unicast/APPLY/GET: one cycle, then RESP.
  - EXEC, broadcast SET: one channel per cycle, index 0..N_CH-1, then RESP.
  - RESP: done=1 and rsp driven, then IDLE.
- Latency, with run at cycle T:
  - unicast/APPLY/GET: done at T+2
  - broadcast: done at T+1+N_CH.
- busy is 1 from T+1 through the done cycle inclusive.
- run while busy, or in the RESP cycle, is ignored: no capture, no side effect.
- Responses:
  - Success on a SET or APPLY: rsp = latched cmd.
  - GET_CTL: rsp = {cmd[31:20], pad zeros, ctl of ch}, ctl right-aligned.
  - Error: rsp = latched cmd with [27:24] forced to 0xF. No state changes.
- Error cases:
  - illegal instr
  - ch >= N_CH and ch != 0xF
  - GET_CTL with ch=0xF.
- APPLY copies all shadow thresholds to live in the EXEC cycle; apply_stb pulses in that same cycle.
- SET_THR never alters the live threshold.
- rsp holds its last value between responses.

Optional Feature:
TAP_CMD_STATS_EN
- With the macro:
  - Two 16-bit saturating counters: cmd_cnt counts accepted TAP commands at capture; err_cnt counts error responses at RESP.
  - GET_STATS (instr 7, ch ignored) returns {cmd_cnt, err_cnt} and does not count itself.
  - Both counters reset to 0.
- Without the macro: instr 7 is illegal and no counters are synthesised.

Decomposition:
- Shared package/defines header holds:
  - field slice positions, TAP target code, instr codes, ERR code 0xF
  - broadcast code 0xF
  - FSM state encodings
  - per-channel ctl bit offsets.
- One natural sub-module: tap_ch_regs, the per-channel live/shadow registers with write-enable, select and apply inputs, instantiated N_CH times via generate.

Test Plan:
- Reset, then cmd={TAP,SET_GT,ch2,payload 1}: done at T+2, rsp==cmd, only ch2 gt=1, busy high for exactly 2 cycles.
- SET_THR ch1 0x1234 (14 bits -> 0x1234), then GET_CTL ch1: live thr still THR_INIT. After APPLY: live thr=0x1234, apply_stb single pulse, and GET_CTL ch1 returns thr 0x1234.
- Broadcast SET_TRIG_EN payload 1 with N_CH=4: done at T+5; all trig_en=1; run pulses during busy are ignored.
- Error cases each produce [27:24]=0xF and ctl unchanged: ch=5 with N_CH=4; GET_CTL ch=0xF; instr 0x9.
- Non-TAP target with run=1: no busy, no done, no ctl change. Assert rst mid-broadcast at cycle T+3: all ctl back to reset values, no done.
- With TAP_CMD_STATS_EN: 3 good commands and 1 bad command, then GET_STATS returns cmd_cnt=4, err_cnt=1. Without the macro, instr 7 returns an error.
